array_allocator: RTL
====================

# array_allocator

Shared array-handle allocator for the Zero VM FPGA core. It owns the array-number space (NArrays handles), the freed-arrays stack and the allocation counters. It serves alloc/free requests from two requesters, the instruction executor and the array-shift/heap maintenance unit, through a round-robin arbiter. Exactly one operation completes per grant.

## Interface
- MemoryElementWidth, 12, width of array handles and counters
- NArrays, 20, total distinct array handles (0 .. NArrays-1)
- NFreedArrays, 20, depth of freed-arrays stack; must be >= NArrays
- clock  input  1  single clock; all state changes on posedge
- reset  input  1  synchronous, active-high; sampled on posedge clock
- req  input  2  per-requester request, level, held until ack
- op  input  2  per-requester operation bit: 0 = alloc, 1 = free
- arrayIn  input  2 x MemoryElementWidth  per-requester handle to free (ignored for alloc)
- ack  output  2  one-cycle completion pulse to the granted requester
- arrayOut  output  MemoryElementWidth  allocated handle, valid while ack
- error  output  1  valid while ack; 1 = operation rejected, no state change
- allocs  output  MemoryElementWidth  high-water handle count (next never-used handle)
- inUse  output  MemoryElementWidth  handles currently allocated
- maxInUse  output  MemoryElementWidth  peak of inUse since reset

## Operation
- State: allocs, freedArraysTop, freedArrays[NFreedArrays], live bit vector live[NArrays], inUse, maxInUse, rrLast (last granted requester).
- FSM states: IDLE, SERVE.
  - IDLE: if no req, stay. Otherwise grant one requester and capture its op and arrayIn. Go to SERVE.
  - SERVE: execute the op, pulse ack[grant] with arrayOut/error, update rrLast, go to IDLE.
- Arbitration: if one req is high, grant it. If both are high, grant the requester that is not rrLast. rrLast resets to 1, so requester 0 wins the first tie.
- Alloc, in priority order:
  - If freedArraysTop > 0: pop. arrayOut = freedArrays[top-1], top--.
  - Else if allocs < NArrays: arrayOut = allocs, allocs++.
  - Else: error=1, arrayOut=0.
  - On success: set live[arrayOut], inUse++, maxInUse = max(maxInUse, inUse+1).
- Free:
  - error=1 if arrayIn >= allocs, or !live[arrayIn] (double free), or freedArraysTop == NFreedArrays.
  - Otherwise push arrayIn, top++, clear live[arrayIn], inUse--. arrayOut = 0.
- The freed stack is LIFO, so the most recently freed handle is reused first.
- Counters never wrap. Overflow is prevented by the error checks.

## Timing
- Reset values: ack=0, arrayOut=0, error=0, allocs=0, inUse=0, maxInUse=0, freedArraysTop=0, live=0, rrLast=1, state=IDLE.
- Latency: req seen high at posedge t in IDLE leads to ack high during cycle t+1 through t+2, i.e. registered at posedge t+1.
- Throughput: one operation per 2 cycles.
- ack is a single-cycle pulse. arrayOut and error are valid only while ack=1 and hold their value otherwise.
- A requester must drop req in the cycle its ack is high. A req still high at the following IDLE posedge is treated as a new request.
- Both req high every cycle: grants alternate 0,1,0,1. Neither requester starves.
- req dropped before ack: the captured operation still completes and ack pulses.
- Reset during SERVE: the pending operation is discarded, no ack is issued, and all state returns to reset values.
- Status outputs (allocs, inUse, maxInUse) update at the same posedge that raises ack.

## Structure
- Package zero_alloc_pkg holds:
  - enum alloc_state_t {IDLE, SERVE}
  - localparams OP_ALLOC=0 and OP_FREE=1
  - default widths shared with the fpga top (MemoryElementWidth, NArrays)
- Sub-module alloc_rr_arbiter (2-way round-robin). Inputs: req[1:0], rrLast, enable. Outputs: grant one-hot, grantIdx. Purely combinational. The parent registers rrLast.
- Freed stack and live vector are inferred registers inside array_allocator.

## Test plan
- After reset, requester 0 issues 3 allocs: handles 0,1,2. allocs=3, inUse=3, maxInUse=3, error=0 each time.
- Free 1 then free 2, then alloc twice: returns 2 then 1 (LIFO). allocs stays 3. inUse goes 1 → 3.
- Free handle 1 twice: first error=0, second error=1 with no change to inUse. Free handle 7 while allocs=3: error=1.
- Allocate 20 handles, then a 21st alloc: error=1, arrayOut=0, allocs=20. Free 5, then alloc: arrayOut=5.
- Both requesters hold alloc req continuously for 8 grants: acks alternate 0,1,0,1…, starting with requester 0 after reset. Handles come out 0..7 in grant order.
- Assert reset in the SERVE cycle of an alloc: no ack. All counters are 0. The next alloc returns handle 0.

Source files
------------

// File: rtl/zero_alloc_pkg.sv
// Shared types and default sizes for the Zero VM array-handle allocator.
// The fpga top uses the same defaults so handle widths stay consistent.
package zero_alloc_pkg;

   localparam int DefaultMemoryElementWidth = 12;
   localparam int DefaultNArrays            = 20;

   localparam logic OP_ALLOC = 1'b0;
   localparam logic OP_FREE  = 1'b1;

   typedef enum logic {IDLE, SERVE} alloc_state_t;

endpackage

// File: rtl/alloc_rr_arbiter.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module alloc_rr_arbiter (
   input  logic [1:0] req,
   input  logic       rrLast,
   input  logic       enable,
   output logic [1:0] grant,
   output logic       grantIdx
);

   always_comb begin
      grantIdx = 1'b0;
      if (req == 2'b11)
         grantIdx = ~rrLast;
      else if (req[1])
         grantIdx = 1'b1;

      grant = 2'b00;
      if (enable && (req != 2'b00))
         grant = grantIdx ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/array_allocator.sv
// Array-handle allocator: hands out never-used handles or recycles freed ones (LIFO),
// serving two requesters one operation per grant.
module array_allocator
   import zero_alloc_pkg::*;
#(
   parameter int MemoryElementWidth = DefaultMemoryElementWidth,
   parameter int NArrays            = DefaultNArrays,
   parameter int NFreedArrays       = DefaultNArrays
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [1:0]                         req,
   input  logic [1:0]                         op,
   input  logic [1:0][MemoryElementWidth-1:0] arrayIn,
   output logic [1:0]                         ack,
   output logic [MemoryElementWidth-1:0]      arrayOut,
   output logic                               error,
   output logic [MemoryElementWidth-1:0]      allocs,
   output logic [MemoryElementWidth-1:0]      inUse,
   output logic [MemoryElementWidth-1:0]      maxInUse
);

   localparam int IdxW   = $clog2(NArrays);
   localparam int StackW = $clog2(NFreedArrays);
   localparam int TopW   = $clog2(NFreedArrays + 1);

   typedef logic [MemoryElementWidth-1:0] elem_t;

   localparam elem_t            ArrayLimit = MemoryElementWidth'(NArrays);
   localparam logic [TopW-1:0]  StackFull  = TopW'(NFreedArrays);

   alloc_state_t       state;
   logic               rrLast;
   logic [1:0]         grant;
   logic               grantIdx;
   logic               grantQ;
   logic               opQ;
   elem_t              arrayInQ;
   logic [TopW-1:0]    freedTop;
   elem_t              freedArrays [NFreedArrays];
   logic [NArrays-1:0] live;

   function automatic elem_t maxOf(input elem_t a, input elem_t b);
      return (a > b) ? a : b;
   endfunction

   alloc_rr_arbiter arbiter (
      .req      (req),
      .rrLast   (rrLast),
      .enable   (state == IDLE),
      .grant    (grant),
      .grantIdx (grantIdx)
   );

   logic [TopW-1:0]   topDec;
   logic [StackW-1:0] popIdx;
   logic [StackW-1:0] pushIdx;
   logic [IdxW-1:0]   allocIdx;
   logic [IdxW-1:0]   freeIdx;
   logic              canPop;
   logic              canFresh;
   logic              allocOk;
   logic              freeOk;
   elem_t             allocVal;

   // Recycled handles take priority over fresh ones so the handle space stays compact.
   always_comb begin
      topDec   = freedTop - 1'b1;
      popIdx   = topDec[StackW-1:0];
      pushIdx  = freedTop[StackW-1:0];
      canPop   = (freedTop != '0);
      canFresh = (allocs < ArrayLimit);
      allocOk  = canPop || canFresh;
      allocVal = canPop ? freedArrays[popIdx] : allocs;
      allocIdx = allocVal[IdxW-1:0];
      freeIdx  = arrayInQ[IdxW-1:0];
      // A handle beyond allocs was never issued, so the live lookup is only trusted below it.
      freeOk   = (arrayInQ < allocs) && live[freeIdx] && (freedTop != StackFull);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rrLast   <= 1'b1;
         ack      <= 2'b00;
         arrayOut <= '0;
         error    <= 1'b0;
         allocs   <= '0;
         inUse    <= '0;
         maxInUse <= '0;
         freedTop <= '0;
         live     <= '0;
      end else begin
         ack <= 2'b00;
         case (state)
            IDLE: begin
               if (grant != 2'b00)
                  state <= SERVE;
            end
            SERVE: begin
               state  <= IDLE;
               rrLast <= grantQ;
               ack    <= grantQ ? 2'b10 : 2'b01;
               if (opQ == OP_ALLOC) begin
                  error    <= !allocOk;
                  arrayOut <= allocOk ? allocVal : '0;
                  if (allocOk) begin
                     live[allocIdx] <= 1'b1;
                     inUse          <= inUse + 1'b1;
                     maxInUse       <= maxOf(maxInUse, inUse + 1'b1);
                     if (canPop)
                        freedTop <= topDec;
                     else
                        allocs <= allocs + 1'b1;
                  end
               end else begin
                  error    <= !freeOk;
                  arrayOut <= '0;
                  if (freeOk) begin
                     live[freeIdx] <= 1'b0;
                     freedTop      <= freedTop + 1'b1;
                     inUse         <= inUse - 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Captured request and stack contents carry no reset; freedTop alone defines validity.
   always_ff @(posedge clock) begin
      if (state == IDLE && grant != 2'b00) begin
         grantQ   <= grant[1];
         opQ      <= op[grantIdx];
         arrayInQ <= arrayIn[grantIdx];
      end
      if (state == SERVE && opQ == OP_FREE && freeOk)
         freedArrays[pushIdx] <= arrayInQ;
   end

endmodule
